mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter LSB_ID_W, default 3, width of the load-buffer entry id.
REQ-002 Parameter IO_MASK, default 2'b11, value of addr[17:16] that marks an I/O address.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_in  in  1  reset, asynchronous, active-low.
REQ-005 rdy_in  in  1  global enable; low freezes the block.
REQ-006 flush  in  1  branch-mispredict flush, single cycle.
REQ-007 mem_din  in  8  RAM read byte; one-cycle read latency.
REQ-008 io_buffer_full  in  1  UART buffer full.
REQ-009 mem_dout  out  8  RAM write byte.
REQ-010 mem_a  out  32  RAM byte address.
REQ-011 mem_wr  out  1  RAM write strobe.
REQ-012 if_req  in  1  fetch request; level, held until if_done.
REQ-013 if_addr  in  32  fetch word address.
REQ-014 if_done  out  1  one-cycle pulse; if_data valid.
REQ-015 if_data  out  32  fetched instruction word.
REQ-016 lsb_load_en, lsb_store_en  in  1  one-cycle LSB request pulses.
REQ-017 lsb_addr  in  32  access address.
REQ-018 lsb_type  in  3  funct3 of the access.
REQ-019 lsb_val  in  32  store data.
REQ-020 lsb_load_id  in  LSB_ID_W  tag of the load.
REQ-021 mem_busy  out  1  high = LSB must not issue.
REQ-022 load_done  out  1  one-cycle pulse; load result valid.
REQ-023 load_id  out  LSB_ID_W  tag echoed from the request.
REQ-024 load_val  out  32  extended load result.

Function
REQ-025 FSM states: IDLE, FETCH, LOAD, STORE, IO_WAIT; mem_busy = (state != IDLE) OR (fetch_turn AND if_req).
REQ-026 In IDLE, an LSB pulse wins over if_req; the LSB pulse is always accepted in the cycle it arrives.
REQ-027 fetch_turn is set when an LSB op completes while if_req is high; it is cleared when a fetch is accepted. Purpose: no fetch starvation.
REQ-028 Byte count N per access: 4 for fetch; from lsb_type[1:0]: 00->1, 01->2, 10->4.
REQ-029 Bytes are little-endian; byte k is at addr+k.
REQ-030 Reads: byte k is addressed in cycle k after acceptance and sampled at the following edge. Done pulse (if_done or load_done) is high in cycle N after acceptance.
REQ-031 Stores: byte k is driven with mem_wr=1 in cycle k after acceptance. The FSM returns to IDLE after N cycles; stores produce no completion pulse.
REQ-032 A store to an I/O address waits in IO_WAIT while io_buffer_full=1, with mem_wr=0.
REQ-033 Load extension: LB/LH sign-extend (funct3 000/001); LBU/LHU zero-extend (100/101); LW unchanged.
REQ-034 mem_wr=0 and mem_a=0 whenever no byte is being transferred.
REQ-035 flush aborts an in-flight FETCH or LOAD: the FSM goes to IDLE the next cycle, no done pulse is emitted, and fetch_turn is cleared.
REQ-036 flush does not abort a STORE or IO_WAIT; the store completes.
REQ-037 Simultaneous flush and LSB store pulse: the store is accepted. Simultaneous flush and LSB load pulse: the load is dropped.
REQ-038 rdy_in=0 holds every register and forces mem_wr=0. On resume, the last unsampled read byte is re-addressed before its sample.
REQ-039 Address increment wraps modulo 2^32.

Reset
REQ-040 When rst_in is low: state=IDLE, fetch_turn=0, byte counter=0, all outputs 0 (mem_busy=0, if_done=0, load_done=0, mem_wr=0).
REQ-041 Reset asserted mid-transfer abandons the transfer immediately, with no done pulse after release.

Structure
REQ-042 Width macros (ADDR_WIDTH, VAL_WIDTH, FUNCT3_WIDTH, LSB_ID_WIDTH), the funct3 constants and the IO address mask live in the shared util header.
REQ-043 No sub-module; load extension is a shared-header function.

Verification
REQ-044 if_req with if_addr=0x100, RAM bytes 13,05,00,00 -> if_done in cycle 4, if_data=0x00000513.
REQ-045 LB at 0x200 holding 0x80, id=5 -> load_done cycle 1, load_val=0xFFFFFF80, load_id=5. Same access as LBU -> 0x00000080.
REQ-046 SH of 0x1234ABCD at 0x300 -> mem_wr cycles 0-1 with 0x300<=CD, 0x301<=AB, no load_done.
REQ-047 SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0, then one write.
REQ-048 LW accepted then flush in cycle 2 -> no load_done, mem_busy low next cycle.
REQ-049 LSB pulses and if_req both pending -> LSB served first, fetch served before the next LSB op (mem_busy held).

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, funct3 encodings, FSM state type and load-extension helpers
// for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned VAL_WIDTH    = 32;
  localparam int unsigned FUNCT3_WIDTH = 3;
  localparam int unsigned LSB_ID_WIDTH = 3;

  localparam logic [1:0] IO_MASK_DEFAULT = 2'b11;

  localparam logic [FUNCT3_WIDTH-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStore,
    StIoWait
  } state_e;

  // Bytes moved by an LSB access; the unused size code 11 is treated as a word.
  function automatic logic [2:0] access_len(input logic [FUNCT3_WIDTH-1:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [VAL_WIDTH-1:0] load_extend(input logic [FUNCT3_WIDTH-1:0] funct3,
                                                       input logic [VAL_WIDTH-1:0]    raw);
    case (funct3)
      F3_LB:   return {{24{raw[7]}}, raw[7:0]};
      F3_LH:   return {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  return {24'b0, raw[7:0]};
      F3_LHU:  return {16'b0, raw[15:0]};
      F3_LW:   return raw;
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and LSB loads/stores
// over a single 8-bit RAM port with one-cycle read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LSB_ID_W = LSB_ID_WIDTH,
  parameter logic [1:0]  IO_MASK  = IO_MASK_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic [7:0]              mem_din,
  input  logic                    io_buffer_full,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_a,
  output logic                    mem_wr,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_done,
  output logic [VAL_WIDTH-1:0]    if_data,
  input  logic                    lsb_load_en,
  input  logic                    lsb_store_en,
  input  logic [ADDR_WIDTH-1:0]   lsb_addr,
  input  logic [FUNCT3_WIDTH-1:0] lsb_type,
  input  logic [VAL_WIDTH-1:0]    lsb_val,
  input  logic [LSB_ID_W-1:0]     lsb_load_id,
  output logic                    mem_busy,
  output logic                    load_done,
  output logic [LSB_ID_W-1:0]     load_id,
  output logic [VAL_WIDTH-1:0]    load_val
);

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              len_q, len_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [FUNCT3_WIDTH-1:0] funct3_q, funct3_d;
  logic [LSB_ID_W-1:0]     id_q, id_d;
  logic [VAL_WIDTH-1:0]    sval_q, sval_d;
  logic [VAL_WIDTH-1:0]    buf_q, buf_d;
  logic                    turn_q, turn_d;
  logic                    rdy_q;

  logic [1:0]              rd_idx;
  logic [VAL_WIDTH-1:0]    word;

  assign mem_busy = (state_q != StIdle) || (turn_q && if_req);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    base_d   = base_q;
    funct3_d = funct3_q;
    id_d     = id_q;
    sval_d   = sval_q;
    buf_d    = buf_q;
    turn_d   = turn_q;

    mem_a     = '0;
    mem_wr    = 1'b0;
    mem_dout  = '0;
    if_done   = 1'b0;
    if_data   = '0;
    load_done = 1'b0;
    load_id   = '0;
    load_val  = '0;

    // Byte cnt-1 was addressed last cycle and is on mem_din now.
    rd_idx = 2'(cnt_q - 3'd1);
    word   = buf_q;
    word[{rd_idx, 3'b000} +: 8] = mem_din;

    if (rdy_in && rst_in) begin
      unique case (state_q)
        StIdle: begin
          if (lsb_store_en) begin
            base_d   = lsb_addr;
            funct3_d = lsb_type;
            sval_d   = lsb_val;
            len_d    = access_len(lsb_type);
            cnt_d    = 3'd0;
            if ((lsb_addr[17:16] == IO_MASK) && io_buffer_full) begin
              state_d = StIoWait;
            end else begin
              mem_a    = lsb_addr;
              mem_wr   = 1'b1;
              mem_dout = lsb_val[7:0];
              if (access_len(lsb_type) == 3'd1) begin
                state_d = StIdle;
                if (if_req) turn_d = 1'b1;
              end else begin
                state_d = StStore;
                cnt_d   = 3'd1;
              end
            end
          end else if (lsb_load_en && !flush) begin
            base_d   = lsb_addr;
            funct3_d = lsb_type;
            id_d     = lsb_load_id;
            len_d    = access_len(lsb_type);
            buf_d    = '0;
            mem_a    = lsb_addr;
            state_d  = StLoad;
            cnt_d    = 3'd1;
          end else if (if_req && !flush) begin
            base_d  = if_addr;
            len_d   = 3'd4;
            buf_d   = '0;
            mem_a   = if_addr;
            state_d = StFetch;
            cnt_d   = 3'd1;
            turn_d  = 1'b0;
          end
        end

        StFetch, StLoad: begin
          if (flush) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
            turn_d  = 1'b0;
          end else if (!rdy_q) begin
            // Resuming after a stall: mem_din is stale, so re-address the pending byte.
            mem_a = base_q + 32'(cnt_q - 3'd1);
          end else begin
            buf_d = word;
            if (cnt_q == len_q) begin
              state_d = StIdle;
              cnt_d   = 3'd0;
              if (state_q == StFetch) begin
                if_done = 1'b1;
                if_data = word;
              end else begin
                load_done = 1'b1;
                load_id   = id_q;
                load_val  = load_extend(funct3_q, word);
                if (if_req) turn_d = 1'b1;
              end
            end else begin
              mem_a = base_q + 32'(cnt_q);
              cnt_d = cnt_q + 3'd1;
            end
          end
        end

        StStore, StIoWait: begin
          if ((base_q[17:16] == IO_MASK) && io_buffer_full) begin
            state_d = StIoWait;
          end else begin
            mem_a    = base_q + 32'(cnt_q);
            mem_wr   = 1'b1;
            mem_dout = sval_q[{cnt_q[1:0], 3'b000} +: 8];
            if (cnt_q + 3'd1 == len_q) begin
              state_d = StIdle;
              cnt_d   = 3'd0;
              if (if_req) turn_d = 1'b1;
            end else begin
              state_d = StStore;
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_q    <= '0;
      base_q   <= '0;
      funct3_q <= '0;
      id_q     <= '0;
      sval_q   <= '0;
      buf_q    <= '0;
      turn_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      base_q   <= base_d;
      funct3_q <= funct3_d;
      id_q     <= id_d;
      sval_q   <= sval_d;
      buf_q    <= buf_d;
      turn_q   <= turn_d;
      rdy_q    <= rdy_in;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous one-cycle-latency ROM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_load_en;
  logic        lsb_store_en;
  logic [31:0] lsb_addr;
  logic [2:0]  lsb_type;
  logic [31:0] lsb_val;
  logic [2:0]  lsb_load_id;
  logic        mem_busy;
  logic        load_done;
  logic [2:0]  load_id;
  logic [31:0] load_val;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .lsb_load_en    (lsb_load_en),
    .lsb_store_en   (lsb_store_en),
    .lsb_addr       (lsb_addr),
    .lsb_type       (lsb_type),
    .lsb_val        (lsb_val),
    .lsb_load_id    (lsb_load_id),
    .mem_busy       (mem_busy),
    .load_done      (load_done),
    .load_id        (load_id),
    .load_val       (load_val)
  );

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'hEE;
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0200: return 8'h80;
      32'h0000_0201: return 8'h11;
      32'h0000_0202: return 8'h22;
      32'h0000_0203: return 8'h33;
      32'hFFFF_FFFF: return 8'h34;
      default:       return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) mem_din <= rom(mem_a);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; lsb_store_en = 1'b0; lsb_type = '0; lsb_val = '0;
    lsb_load_en = 1'b1; lsb_addr = 32'h200; lsb_load_id = 3'd5;
    #3;
    chk("rst_busy", {31'b0, mem_busy}, 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);
    chk("rst_if_done", {31'b0, if_done}, 32'd0);
    cyc(); cyc();
    lsb_load_en = 1'b0; rst_in = 1'b1;

    // Instruction fetch of 0x00000513 at 0x100
    cyc(); if_req = 1'b1; if_addr = 32'h100; #2;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin cyc(); #2; end
      chk("fetch_done", {31'b0, if_done}, (k == 4) ? 32'd1 : 32'd0);
      chk("fetch_addr", mem_a, (k < 4) ? 32'h100 + 32'(k) : 32'h0);
    end
    chk("fetch_data", if_data, 32'h0000_0513);
    cyc(); if_req = 1'b0; #2;
    chk("fetch_pulse", {31'b0, if_done}, 32'd0);

    // LB / LBU at 0x200 holding 0x80
    cyc(); lsb_load_en = 1'b1; lsb_addr = 32'h200; lsb_type = 3'b000; lsb_load_id = 3'd5; #2;
    chk("lb_addr", mem_a, 32'h200);
    chk("lb_done0", {31'b0, load_done}, 32'd0);
    cyc(); lsb_load_en = 1'b0; #2;
    chk("lb_done1", {31'b0, load_done}, 32'd1);
    chk("lb_val", load_val, 32'hFFFF_FF80);
    chk("lb_id", {29'b0, load_id}, 32'd5);
    cyc(); #2;
    chk("lb_pulse", {31'b0, load_done}, 32'd0);
    chk("lb_busy", {31'b0, mem_busy}, 32'd0);
    cyc(); lsb_load_en = 1'b1; lsb_type = 3'b100; #2;
    cyc(); lsb_load_en = 1'b0; #2;
    chk("lbu_done", {31'b0, load_done}, 32'd1);
    chk("lbu_val", load_val, 32'h0000_0080);

    // SH of 0x1234ABCD at 0x300
    cyc(); lsb_store_en = 1'b1; lsb_addr = 32'h300; lsb_type = 3'b001; lsb_val = 32'h1234_ABCD;
    #2;
    chk("sh_wr0", {31'b0, mem_wr}, 32'd1);
    chk("sh_a0", mem_a, 32'h300);
    chk("sh_d0", {24'b0, mem_dout}, 32'hCD);
    cyc(); lsb_store_en = 1'b0; #2;
    chk("sh_wr1", {31'b0, mem_wr}, 32'd1);
    chk("sh_a1", mem_a, 32'h301);
    chk("sh_d1", {24'b0, mem_dout}, 32'hAB);
    chk("sh_nodone", {31'b0, load_done}, 32'd0);
    cyc(); #2;
    chk("sh_wr2", {31'b0, mem_wr}, 32'd0);
    chk("sh_busy2", {31'b0, mem_busy}, 32'd0);
    chk("sh_nodone2", {31'b0, load_done}, 32'd0);

    // SB to I/O address while the UART buffer is full for three cycles
    cyc(); lsb_store_en = 1'b1; lsb_addr = 32'h3_0000; lsb_type = 3'b000; lsb_val = 32'h41;
    io_buffer_full = 1'b1; #2;
    chk("io_wr0", {31'b0, mem_wr}, 32'd0);
    chk("io_a0", mem_a, 32'h0);
    cyc(); lsb_store_en = 1'b0; #2;
    chk("io_wr1", {31'b0, mem_wr}, 32'd0);
    cyc(); #2;
    chk("io_wr2", {31'b0, mem_wr}, 32'd0);
    chk("io_busy2", {31'b0, mem_busy}, 32'd1);
    cyc(); io_buffer_full = 1'b0; #2;
    chk("io_wr3", {31'b0, mem_wr}, 32'd1);
    chk("io_a3", mem_a, 32'h3_0000);
    chk("io_d3", {24'b0, mem_dout}, 32'h41);
    cyc(); #2;
    chk("io_wr4", {31'b0, mem_wr}, 32'd0);
    chk("io_busy4", {31'b0, mem_busy}, 32'd0);

    // LW aborted by flush in cycle 2
    cyc(); lsb_load_en = 1'b1; lsb_addr = 32'h200; lsb_type = 3'b010; lsb_load_id = 3'd2; #2;
    cyc(); lsb_load_en = 1'b0; #2;
    cyc(); flush = 1'b1; #2;
    chk("fl_done2", {31'b0, load_done}, 32'd0);
    cyc(); flush = 1'b0; #2;
    chk("fl_busy3", {31'b0, mem_busy}, 32'd0);
    chk("fl_done3", {31'b0, load_done}, 32'd0);
    cyc(); #2;
    chk("fl_done4", {31'b0, load_done}, 32'd0);
    cyc(); #2;
    chk("fl_done5", {31'b0, load_done}, 32'd0);

    // LSB and fetch pending together: LSB first, then the fetch holds off the LSB
    cyc(); if_req = 1'b1; if_addr = 32'h100;
    lsb_load_en = 1'b1; lsb_addr = 32'h200; lsb_type = 3'b000; lsb_load_id = 3'd3; #2;
    chk("arb_lsb_first", mem_a, 32'h200);
    cyc(); lsb_load_en = 1'b0; #2;
    chk("arb_load_done", {31'b0, load_done}, 32'd1);
    chk("arb_load_id", {29'b0, load_id}, 32'd3);
    cyc(); #2;
    chk("arb_busy", {31'b0, mem_busy}, 32'd1);
    chk("arb_fetch_a", mem_a, 32'h100);
    repeat (3) cyc();
    cyc(); #2;
    chk("arb_if_done", {31'b0, if_done}, 32'd1);
    chk("arb_if_data", if_data, 32'h0000_0513);
    cyc(); if_req = 1'b0; #2;
    chk("arb_busy_end", {31'b0, mem_busy}, 32'd0);

    // LW with a one-cycle stall; the pending byte must be re-read after resume
    cyc(); lsb_load_en = 1'b1; lsb_addr = 32'h200; lsb_type = 3'b010; lsb_load_id = 3'd1; #2;
    chk("st_a0", mem_a, 32'h200);
    cyc(); lsb_load_en = 1'b0; rdy_in = 1'b0; #2;
    chk("st_a_frozen", mem_a, 32'h0);
    chk("st_wr_frozen", {31'b0, mem_wr}, 32'd0);
    chk("st_done_frozen", {31'b0, load_done}, 32'd0);
    cyc(); rdy_in = 1'b1; #2;
    chk("st_readdr", mem_a, 32'h200);
    cyc(); #2;
    chk("st_a1", mem_a, 32'h201);
    cyc(); cyc(); cyc(); #2;
    chk("st_done", {31'b0, load_done}, 32'd1);
    chk("st_val", load_val, 32'h3322_1180);
    chk("st_id", {29'b0, load_id}, 32'd1);

    // LH across the top of the address space
    cyc(); lsb_load_en = 1'b1; lsb_addr = 32'hFFFF_FFFF; lsb_type = 3'b001; lsb_load_id = 3'd4;
    #2;
    chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
    cyc(); lsb_load_en = 1'b0; #2;
    chk("wrap_a1", mem_a, 32'h0);
    cyc(); #2;
    chk("wrap_done", {31'b0, load_done}, 32'd1);
    chk("wrap_val", load_val, 32'hFFFF_EE34);

    // Flush together with a store pulse keeps the store; with a load pulse drops it
    cyc(); lsb_store_en = 1'b1; flush = 1'b1; lsb_addr = 32'h310; lsb_type = 3'b000;
    lsb_val = 32'h5A; #2;
    chk("fst_wr", {31'b0, mem_wr}, 32'd1);
    chk("fst_a", mem_a, 32'h310);
    chk("fst_d", {24'b0, mem_dout}, 32'h5A);
    cyc(); lsb_store_en = 1'b0; lsb_load_en = 1'b1; lsb_addr = 32'h200; #2;
    chk("fld_a", mem_a, 32'h0);
    cyc(); lsb_load_en = 1'b0; flush = 1'b0; #2;
    chk("fld_busy", {31'b0, mem_busy}, 32'd0);
    chk("fld_done", {31'b0, load_done}, 32'd0);

    // SW is not aborted by a flush mid-way
    cyc(); lsb_store_en = 1'b1; lsb_addr = 32'h320; lsb_type = 3'b010; lsb_val = 32'hDEAD_BEEF;
    #2;
    chk("sw_d0", {24'b0, mem_dout}, 32'hEF);
    cyc(); lsb_store_en = 1'b0; flush = 1'b1; #2;
    chk("sw_wr1", {31'b0, mem_wr}, 32'd1);
    chk("sw_a1", mem_a, 32'h321);
    chk("sw_d1", {24'b0, mem_dout}, 32'hBE);
    cyc(); flush = 1'b0; #2;
    chk("sw_d2", {24'b0, mem_dout}, 32'hAD);
    cyc(); #2;
    chk("sw_a3", mem_a, 32'h323);
    chk("sw_d3", {24'b0, mem_dout}, 32'hDE);
    cyc(); #2;
    chk("sw_wr4", {31'b0, mem_wr}, 32'd0);

    // Reset mid-fetch abandons the transfer
    cyc(); if_req = 1'b1; if_addr = 32'h100; #2;
    cyc(); #2;
    cyc(); rst_in = 1'b0; #2;
    chk("mrst_busy", {31'b0, mem_busy}, 32'd0);
    chk("mrst_a", mem_a, 32'h0);
    cyc(); if_req = 1'b0; rst_in = 1'b1; #2;
    for (int k = 0; k < 4; k++) begin
      chk("mrst_no_done", {31'b0, if_done}, 32'd0);
      chk("mrst_idle", {31'b0, mem_busy}, 32'd0);
      cyc(); #2;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
